move_ram_write_arbiter: RTL and testbench

- Owns the single write port of the 32-bit x 16384-entry result RAM.
- Shares that port between two requesters:
  - Avalon host writes (pass-through, absolute priority).
  - The move-generation engine's result stream.
- Engine results are buffered in a small FIFO and written to sequential RAM addresses from RESULT_BASE upward.
- Sequences a start/collect/drain/done handshake. The slave maps this handshake onto its control word (start, done, reset bits).

---
 rtl/move_ram_write_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_move_ram_write_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_ram_write_arbiter.sv
// Write-port arbiter for the result RAM: host writes pass straight through with absolute
// priority, engine results are buffered in a small FIFO and written from RESULT_BASE upward.
module move_ram_write_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned RESULT_BASE = 16,
    parameter int unsigned MAX_RESULTS = (1 << ADDR_WIDTH) - RESULT_BASE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  host_wr_en,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    input  logic                  eng_valid,
    output logic                  eng_ready,
    input  logic [DATA_WIDTH-1:0] eng_data,
    input  logic                  eng_last,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_wraddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] result_count,
    output logic                  overflow
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StDrain   = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    localparam logic [PtrW:0]         FifoFull = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(RESULT_BASE);
    localparam logic [ADDR_WIDTH-1:0] MaxCount = ADDR_WIDTH'(MAX_RESULTS);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]         fifo_cnt_q, fifo_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] result_count_q, result_count_d;
    logic                  overflow_q, overflow_d;
    logic                  ram_wren_q, ram_wren_d;
    logic [ADDR_WIDTH-1:0] ram_wraddr_q, ram_wraddr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic pop_keep;

    always_comb begin
        fifo_empty = (fifo_cnt_q == '0);
        fifo_full  = (fifo_cnt_q == FifoFull);
        eng_ready  = (state_q == StCollect) && !fifo_full;
        push       = eng_valid && eng_ready;
        pop        = !host_wr_en && !fifo_empty;
        // Pops past capacity still drain the FIFO but never reach the RAM.
        pop_keep   = pop && (result_count_q != MaxCount);
    end

    always_comb begin
        state_d        = state_q;
        fifo_mem_d     = fifo_mem_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        fifo_cnt_d     = fifo_cnt_q;
        wr_addr_d      = wr_addr_q;
        result_count_d = result_count_q;
        overflow_d     = overflow_q;
        ram_wren_d     = 1'b0;
        ram_wraddr_d   = ram_wraddr_q;
        ram_wdata_d    = ram_wdata_q;

        if (push) begin
            fifo_mem_d[wr_ptr_q] = eng_data;
            wr_ptr_d             = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + (PtrW + 1)'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - (PtrW + 1)'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        if (host_wr_en) begin
            ram_wren_d   = 1'b1;
            ram_wraddr_d = host_wr_addr;
            ram_wdata_d  = host_wr_data;
        end else if (pop_keep) begin
            ram_wren_d     = 1'b1;
            ram_wraddr_d   = wr_addr_q;
            ram_wdata_d    = fifo_mem_q[rd_ptr_q];
            wr_addr_d      = wr_addr_q + ADDR_WIDTH'(1);
            result_count_d = result_count_q + ADDR_WIDTH'(1);
        end else if (pop) begin
            overflow_d = 1'b1;
        end

        // The FIFO is always empty in IDLE and DONE, so run initialisation never races a pop.
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d        = StCollect;
                    wr_addr_d      = BaseAddr;
                    result_count_d = '0;
                    overflow_d     = 1'b0;
                end
            end
            StCollect: begin
                if (push && eng_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (fifo_empty) begin
                    state_d = StDone;
                end
            end
            default: begin
                if (start) begin
                    state_d        = StCollect;
                    wr_addr_d      = BaseAddr;
                    result_count_d = '0;
                    overflow_d     = 1'b0;
                end else if (clear) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            wr_addr_q      <= BaseAddr;
            result_count_q <= '0;
            overflow_q     <= 1'b0;
            ram_wren_q     <= 1'b0;
            ram_wraddr_q   <= '0;
            ram_wdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            wr_addr_q      <= wr_addr_d;
            result_count_q <= result_count_d;
            overflow_q     <= overflow_d;
            ram_wren_q     <= ram_wren_d;
            ram_wraddr_q   <= ram_wraddr_d;
            ram_wdata_q    <= ram_wdata_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign ram_wren     = ram_wren_q;
    assign ram_wraddr   = ram_wraddr_q;
    assign ram_wdata    = ram_wdata_q;
    assign busy         = (state_q == StCollect) || (state_q == StDrain);
    assign done         = (state_q == StDone);
    assign result_count = result_count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_move_ram_write_arbiter.sv
// Bench for move_ram_write_arbiter: two instances (default capacity and capacity 3) share one
// random stimulus stream and are compared every cycle against a queue-based reference model.
module tb_move_ram_write_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int BASE = 16;
    localparam int IDLE = 0;
    localparam int COLLECT = 1;
    localparam int DRAIN = 2;
    localparam int DONE = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          host_wr_en = 1'b0;
    logic [AW-1:0] host_wr_addr = '0;
    logic [DW-1:0] host_wr_data = '0;
    logic          eng_valid = 1'b0;
    logic [DW-1:0] eng_data = '0;
    logic          eng_last = 1'b0;

    logic          eng_ready0, ram_wren0, busy0, done0, overflow0;
    logic [AW-1:0] ram_wraddr0, result_count0;
    logic [DW-1:0] ram_wdata0;
    logic          eng_ready1, ram_wren1, busy1, done1, overflow1;
    logic [AW-1:0] ram_wraddr1, result_count1;
    logic [DW-1:0] ram_wdata1;

    move_ram_write_arbiter u_dut0 (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .eng_valid(eng_valid), .eng_ready(eng_ready0), .eng_data(eng_data), .eng_last(eng_last),
        .ram_wren(ram_wren0), .ram_wraddr(ram_wraddr0), .ram_wdata(ram_wdata0),
        .busy(busy0), .done(done0), .result_count(result_count0), .overflow(overflow0)
    );

    move_ram_write_arbiter #(.MAX_RESULTS(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .eng_valid(eng_valid), .eng_ready(eng_ready1), .eng_data(eng_data), .eng_last(eng_last),
        .ram_wren(ram_wren1), .ram_wraddr(ram_wraddr1), .ram_wdata(ram_wdata1),
        .busy(busy1), .done(done1), .result_count(result_count1), .overflow(overflow1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state, one slot per instance.
    int            m_st [2];
    int            m_cnt [2];
    int            m_max [2];
    bit            m_ovf [2];
    bit            m_wren [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    logic [DW-1:0] m_q [2][$];

    int unsigned eng_prob = 100;
    int unsigned host_prob = 0;
    int          host_hold = 0;
    int          to_send = 0;
    int          wr_seen0 = 0;
    int          wr_seen1 = 0;
    logic [AW-1:0] last_addr0 = '0;
    logic [AW-1:0] last_addr1 = '0;
    logic [DW-1:0] last_data0 = '0;
    logic [DW-1:0] single_data = '0;

    function automatic bit model_ready(input int m);
        return (m_st[m] == COLLECT) && (m_q[m].size() < DEPTH);
    endfunction

    task automatic model_step(input int m);
        int            pre;
        bit            rdy;
        logic [DW-1:0] d;
        if (!reset) begin
            m_st[m] = IDLE; m_cnt[m] = 0; m_ovf[m] = 0;
            m_wren[m] = 0; m_addr[m] = '0; m_data[m] = '0;
            m_q[m].delete();
            return;
        end
        pre = m_q[m].size();
        rdy = model_ready(m);
        m_wren[m] = 0;
        if (host_wr_en) begin
            m_wren[m] = 1; m_addr[m] = host_wr_addr; m_data[m] = host_wr_data;
        end else if (pre > 0) begin
            d = m_q[m].pop_front();
            if (m_cnt[m] == m_max[m]) begin
                m_ovf[m] = 1;
            end else begin
                m_wren[m] = 1;
                m_addr[m] = AW'(BASE + m_cnt[m]);
                m_data[m] = d;
                m_cnt[m]++;
            end
        end
        if (rdy && eng_valid) m_q[m].push_back(eng_data);
        case (m_st[m])
            IDLE: if (start) begin m_st[m] = COLLECT; m_cnt[m] = 0; m_ovf[m] = 0; end
            COLLECT: if (rdy && eng_valid && eng_last) m_st[m] = DRAIN;
            DRAIN: if (pre == 0) m_st[m] = DONE;
            default: begin
                if (start) begin
                    m_st[m] = COLLECT; m_cnt[m] = 0; m_ovf[m] = 0;
                end else if (clear) begin
                    m_st[m] = IDLE;
                end
            end
        endcase
    endtask

    task automatic compare();
        check_eq("wren0", 32'(ram_wren0), 32'(m_wren[0]));
        if (m_wren[0]) begin
            check_eq("waddr0", 32'(ram_wraddr0), 32'(m_addr[0]));
            check_eq("wdata0", ram_wdata0, m_data[0]);
        end
        check_eq("ready0", 32'(eng_ready0), 32'(model_ready(0)));
        check_eq("busy0", 32'(busy0), 32'(m_st[0] == COLLECT || m_st[0] == DRAIN));
        check_eq("done0", 32'(done0), 32'(m_st[0] == DONE));
        check_eq("count0", 32'(result_count0), 32'(m_cnt[0]));
        check_eq("ovf0", 32'(overflow0), 32'(m_ovf[0]));
        check_eq("wren1", 32'(ram_wren1), 32'(m_wren[1]));
        if (m_wren[1]) begin
            check_eq("waddr1", 32'(ram_wraddr1), 32'(m_addr[1]));
            check_eq("wdata1", ram_wdata1, m_data[1]);
        end
        check_eq("ready1", 32'(eng_ready1), 32'(model_ready(1)));
        check_eq("done1", 32'(done1), 32'(m_st[1] == DONE));
        check_eq("count1", 32'(result_count1), 32'(m_cnt[1]));
        check_eq("ovf1", 32'(overflow1), 32'(m_ovf[1]));
        if (ram_wren0) begin wr_seen0++; last_addr0 = ram_wraddr0; last_data0 = ram_wdata0; end
        if (ram_wren1) begin wr_seen1++; last_addr1 = ram_wraddr1; end
    endtask

    // One clock: advance the model on the current inputs, then check and drive the next cycle.
    task automatic tick();
        bit acc;
        acc = eng_valid && model_ready(0);
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        compare();
        start = 1'b0;
        clear = 1'b0;
        if (acc && to_send > 0) to_send--;
        if (to_send > 0) begin
            eng_valid = ($urandom_range(0, 99) < eng_prob);
            eng_data  = $urandom();
            eng_last  = (to_send == 1);
        end else if (acc) begin
            eng_valid = 1'b0;
            eng_last  = 1'b0;
        end
        if (host_hold > 0) begin
            host_wr_en = 1'b1;
            host_hold--;
        end else begin
            host_wr_en = ($urandom_range(0, 99) < host_prob);
        end
        host_wr_addr = AW'($urandom());
        host_wr_data = $urandom();
    endtask

    task automatic start_stream(input int n);
        to_send   = n;
        eng_valid = 1'b1;
        eng_data  = $urandom();
        eng_last  = (n == 1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done0 !== 1'b1; i++) tick();
        check_eq("wait_done", 32'(done0), 32'd1);
    endtask

    initial begin
        m_max[0] = (1 << AW) - BASE;
        m_max[1] = 3;
        repeat (3) tick();
        check_eq("rst_waddr", 32'(ram_wraddr0), 32'd0);
        check_eq("rst_wdata", ram_wdata0, 32'd0);
        check_eq("rst_count", 32'(result_count0), 32'd0);
        reset = 1'b1;

        // Engine noise while idle must be ignored.
        eng_valid = 1'b1;
        repeat (3) tick();
        eng_valid = 1'b0;
        check_eq("idle_writes", 32'(wr_seen0), 32'd0);
        check_eq("idle_ready", 32'(eng_ready0), 32'd0);

        // Ten back-to-back moves; the capacity-3 instance overflows on the same stream.
        start = 1'b1;
        tick();
        wr_seen0 = 0; wr_seen1 = 0;
        start_stream(10);
        wait_done(60);
        check_eq("run10_count", 32'(result_count0), 32'd10);
        check_eq("run10_writes", 32'(wr_seen0), 32'd10);
        check_eq("run10_last", 32'(last_addr0), 32'd25);
        check_eq("run10_busy", 32'(busy0), 32'd0);
        check_eq("cap_count", 32'(result_count1), 32'd3);
        check_eq("cap_ovf", 32'(overflow1), 32'd1);
        check_eq("cap_writes", 32'(wr_seen1), 32'd3);

        // Engine noise in DONE must be ignored too.
        eng_valid = 1'b1;
        repeat (3) tick();
        eng_valid = 1'b0;
        check_eq("done_count", 32'(result_count0), 32'd10);
        check_eq("done_writes", 32'(wr_seen0), 32'd10);

        // start and clear together restart the run.
        start = 1'b1; clear = 1'b1;
        tick();
        check_eq("sc_busy", 32'(busy0), 32'd1);
        check_eq("sc_count", 32'(result_count0), 32'd0);
        check_eq("sc_ovf", 32'(overflow1), 32'd0);
        start_stream(1);
        single_data = eng_data;
        wait_done(30);
        check_eq("single_count", 32'(result_count0), 32'd1);
        check_eq("single_addr", 32'(last_addr0), 32'd16);
        check_eq("single_data", last_data0, single_data);
        clear = 1'b1;
        tick();
        check_eq("clear_done", 32'(done0), 32'd0);

        // Five results against the capacity-3 instance.
        start = 1'b1;
        tick();
        wr_seen1 = 0;
        start_stream(5);
        wait_done(40);
        check_eq("cap5_count1", 32'(result_count1), 32'd3);
        check_eq("cap5_ovf1", 32'(overflow1), 32'd1);
        check_eq("cap5_writes1", 32'(wr_seen1), 32'd3);
        check_eq("cap5_last1", 32'(last_addr1), 32'd18);
        check_eq("cap5_count0", 32'(result_count0), 32'd5);
        clear = 1'b1;
        tick();

        // Host holds the port for six cycles mid-stream; the FIFO must fill and stall the engine.
        start = 1'b1;
        tick();
        wr_seen0 = 0;
        start_stream(12);
        for (int i = 0; i < 40 && to_send > 9; i++) tick();
        host_wr_en = 1'b1;
        host_hold = 5;
        repeat (6) tick();
        check_eq("host_full_ready", 32'(eng_ready0), 32'd0);
        wait_done(80);
        check_eq("host_count", 32'(result_count0), 32'd12);
        check_eq("host_writes", 32'(wr_seen0), 32'd18);
        clear = 1'b1;
        tick();

        // Random runs with host traffic and stray start/clear pulses.
        host_prob = 20;
        eng_prob = 60;
        for (int r = 0; r < 8; r++) begin
            start = 1'b1;
            clear = 1'($urandom_range(0, 1));
            tick();
            start_stream(int'($urandom_range(1, 9)));
            for (int i = 0; i < 200 && done0 !== 1'b1; i++) begin
                start = ($urandom_range(0, 99) < 5);
                clear = ($urandom_range(0, 99) < 5);
                tick();
            end
            check_eq("rnd_done", 32'(done0), 32'd1);
            if (r % 2 == 1) begin
                clear = 1'b1;
                tick();
            end
        end
        host_prob = 0;
        eng_prob = 100;

        // Reset in DRAIN with three results still queued behind a host burst.
        start = 1'b1;
        tick();
        host_wr_en = 1'b1;
        host_hold = 30;
        start_stream(3);
        for (int i = 0; i < 20 && m_st[0] != DRAIN; i++) tick();
        check_eq("pre_rst_busy", 32'(busy0), 32'd1);
        reset = 1'b0;
        host_hold = 0; host_wr_en = 1'b0; to_send = 0; eng_valid = 1'b0; eng_last = 1'b0;
        tick();
        check_eq("mid_rst_wren", 32'(ram_wren0), 32'd0);
        check_eq("mid_rst_waddr", 32'(ram_wraddr0), 32'd0);
        check_eq("mid_rst_wdata", ram_wdata0, 32'd0);
        check_eq("mid_rst_busy", 32'(busy0), 32'd0);
        check_eq("mid_rst_count", 32'(result_count0), 32'd0);
        reset = 1'b1;
        wr_seen0 = 0;
        repeat (6) tick();
        check_eq("post_rst_writes", 32'(wr_seen0), 32'd0);
        check_eq("post_rst_done", 32'(done0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
